// File: rtl/rx_boxcar_decim_pkg.sv
// rx_boxcar_decim_pkg: shared widths, shift width and overflow flag bit indices
package rx_boxcar_decim_pkg;
  localparam int IN_WIDTH_DEF  = 16;
  localparam int ACC_WIDTH_DEF = 24;
  localparam int OUT_WIDTH_DEF = 16;
  localparam int SHIFT_W       = 4;
  localparam int OVF_ACC       = 0;
  localparam int OVF_OUT       = 1;
endpackage

// File: rtl/rx_boxcar_decim_chan.sv
// rx_boxcar_decim_chan: one boxcar channel (accumulator, stage-1 dump register, round/shift/saturate)
//  clock, reset_n          clock and asynchronous active-low reset
//  enable                  low clears the accumulator
//  sample_strobe, x_in     input sample and its qualifier
//  dump_strobe             end of window; loads stage 1 and restarts the accumulator
//  load_out, shift         stage-2 load of x_out using the given right shift
//  x_out                   rounded, scaled, saturated dump value
//  acc_sat, out_sat        one-cycle saturation event pulses
module rx_boxcar_decim_chan
  import rx_boxcar_decim_pkg::*;
#(
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic                        sample_strobe,
  input  logic                        dump_strobe,
  input  logic                        load_out,
  input  logic signed [IN_WIDTH-1:0]  x_in,
  input  logic [SHIFT_W-1:0]          shift,
  output logic signed [OUT_WIDTH-1:0] x_out,
  output logic                        acc_sat,
  output logic                        out_sat
);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH:0]   OUT_MAX = (ACC_WIDTH+1)'((64'sd1 <<< (OUT_WIDTH-1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH:0]   OUT_MIN = ~OUT_MAX;
  logic signed [ACC_WIDTH-1:0] acc, s1, sat_sum;
  logic signed [ACC_WIDTH:0]   x_ext, sum_wide, biased, shifted;
  logic [ACC_WIDTH:0]          bias;
  logic                        acc_ovf, out_hi, out_lo;
  // one guard bit: overflow shows up as the top two bits disagreeing
  assign x_ext    = sample_strobe ? (ACC_WIDTH+1)'(x_in) : '0;
  assign sum_wide = {acc[ACC_WIDTH-1], acc} + x_ext;
  assign acc_ovf  = sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1];
  assign sat_sum  = acc_ovf ? (sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : sum_wide[ACC_WIDTH-1:0];
  assign acc_sat  = enable & acc_ovf;
  // adding half an LSB before the arithmetic shift rounds half toward +inf
  assign bias     = (shift == '0) ? '0 : ((ACC_WIDTH+1)'(1) << (shift - 1'b1));
  assign biased   = {s1[ACC_WIDTH-1], s1} + bias;
  assign shifted  = biased >>> shift;
  assign out_hi   = shifted > OUT_MAX;
  assign out_lo   = shifted < OUT_MIN;
  assign out_sat  = load_out & (out_hi | out_lo);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc   <= '0;
      s1    <= '0;
      x_out <= '0;
    end else begin
      if (!enable) acc <= '0;
      else if (dump_strobe) begin
        s1  <= sat_sum;
        acc <= '0;
      end else if (sample_strobe) acc <= sat_sum;
      if (load_out) x_out <= out_hi ? OUT_MAX[OUT_WIDTH-1:0] : out_lo ? OUT_MIN[OUT_WIDTH-1:0] : shifted[OUT_WIDTH-1:0];
    end
  end
endmodule

// File: rtl/rx_boxcar_decim.sv
// rx_boxcar_decim: I/Q integrate-and-dump decimator with rounding, scaling and sticky overflow flags
//  clock, reset_n          clock and asynchronous active-low reset
//  enable                  low clears accumulators and flushes the valid pipeline
//  sample_strobe, i_in/q_in input samples
//  dump_strobe             end-of-window strobe
//  shift                   right shift applied at stage 2
//  clear_ovf               clears the sticky flags (a same-edge event wins)
//  i_out/q_out, out_strobe decimated output and its one-cycle valid
//  ovf_flags               sticky [OVF_ACC] accumulator, [OVF_OUT] output saturation
module rx_boxcar_decim
  import rx_boxcar_decim_pkg::*;
#(
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic                        sample_strobe,
  input  logic                        dump_strobe,
  input  logic signed [IN_WIDTH-1:0]  i_in,
  input  logic signed [IN_WIDTH-1:0]  q_in,
  input  logic [SHIFT_W-1:0]          shift,
  input  logic                        clear_ovf,
  output logic signed [OUT_WIDTH-1:0] i_out,
  output logic signed [OUT_WIDTH-1:0] q_out,
  output logic                        out_strobe,
  output logic [1:0]                  ovf_flags
);
  logic       s1_valid, load_out, i_acc_sat, q_acc_sat, i_out_sat, q_out_sat;
  logic [1:0] ovf_evt;
  // a dump sitting in stage 1 is dropped if enable falls before stage 2
  assign load_out = s1_valid & enable;
  rx_boxcar_decim_chan #(.IN_WIDTH(IN_WIDTH), .ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_i (
    .clock(clock), .reset_n(reset_n), .enable(enable), .sample_strobe(sample_strobe),
    .dump_strobe(dump_strobe), .load_out(load_out), .x_in(i_in), .shift(shift),
    .x_out(i_out), .acc_sat(i_acc_sat), .out_sat(i_out_sat)
  );
  rx_boxcar_decim_chan #(.IN_WIDTH(IN_WIDTH), .ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_q (
    .clock(clock), .reset_n(reset_n), .enable(enable), .sample_strobe(sample_strobe),
    .dump_strobe(dump_strobe), .load_out(load_out), .x_in(q_in), .shift(shift),
    .x_out(q_out), .acc_sat(q_acc_sat), .out_sat(q_out_sat)
  );
  always_comb begin
    ovf_evt          = '0;
    ovf_evt[OVF_ACC] = i_acc_sat | q_acc_sat;
    ovf_evt[OVF_OUT] = i_out_sat | q_out_sat;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid   <= 1'b0;
      out_strobe <= 1'b0;
      ovf_flags  <= '0;
    end else begin
      s1_valid   <= enable & dump_strobe;
      out_strobe <= load_out;
      ovf_flags  <= (clear_ovf ? 2'b00 : ovf_flags) | ovf_evt;
    end
  end
endmodule

// File: tb/tb_rx_boxcar_decim.sv
// tb_rx_boxcar_decim: directed and randomized checks of rx_boxcar_decim against an integer model
module tb_rx_boxcar_decim;
  localparam longint AMAX = 8388607;
  localparam longint AMIN = -8388608;
  localparam longint OMAX = 32767;
  localparam longint OMIN = -32768;
  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               enable = 1'b0;
  logic               sample_strobe = 1'b0;
  logic               dump_strobe = 1'b0;
  logic signed [15:0] i_in = '0;
  logic signed [15:0] q_in = '0;
  logic [3:0]         shift = '0;
  logic               clear_ovf = 1'b0;
  logic signed [15:0] i_out, q_out;
  logic               out_strobe;
  logic [1:0]         ovf_flags;
  int                 n_tests = 0;
  int                 n_fail = 0;
  longint             macc [2];
  longint             ms1 [2];
  longint             mout [2];
  bit                 ms1v, mstb;
  logic [1:0]         mflags;

  rx_boxcar_decim dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .sample_strobe(sample_strobe),
    .dump_strobe(dump_strobe), .i_in(i_in), .q_in(q_in), .shift(shift), .clear_ovf(clear_ovf),
    .i_out(i_out), .q_out(q_out), .out_strobe(out_strobe), .ovf_flags(ovf_flags)
  );

  always #5 clock = ~clock;

  function automatic longint floor_div(longint a, longint d);
    longint r = a / d;
    if ((a % d != 0) && (a < 0)) r--;
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      macc[c] = 0;
      ms1[c]  = 0;
      mout[c] = 0;
    end
    ms1v   = 0;
    mstb   = 0;
    mflags = 2'b00;
  endtask

  task automatic cyc(input bit en, input bit ss, input bit ds, input int iv, input int qv, input int sh, input bit clr);
    longint     x [2];
    longint     s, r;
    logic [1:0] ev = 2'b00;
    enable        = en;
    sample_strobe = ss;
    dump_strobe   = ds;
    i_in          = 16'(iv);
    q_in          = 16'(qv);
    shift         = 4'(sh);
    clear_ovf     = clr;
    x[0] = iv;
    x[1] = qv;
    if (!en) begin
      macc[0] = 0;
      macc[1] = 0;
      ms1v    = 0;
      mstb    = 0;
    end else begin
      mstb = ms1v;
      if (ms1v)
        for (int c = 0; c < 2; c++) begin
          r = floor_div(ms1[c] + (sh != 0 ? (longint'(1) << (sh - 1)) : 0), longint'(1) << sh);
          if (r > OMAX) begin r = OMAX; ev[1] = 1'b1; end
          if (r < OMIN) begin r = OMIN; ev[1] = 1'b1; end
          mout[c] = r;
        end
      for (int c = 0; c < 2; c++) begin
        s = macc[c] + (ss ? x[c] : 0);
        if (s > AMAX) begin s = AMAX; ev[0] = 1'b1; end
        if (s < AMIN) begin s = AMIN; ev[0] = 1'b1; end
        if (ds) begin
          ms1[c]  = s;
          macc[c] = 0;
        end else if (ss) macc[c] = s;
      end
      ms1v = ds;
    end
    mflags = (clr ? 2'b00 : mflags) | ev;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_tests++;
    if (i_out !== 16'sd0 || q_out !== 16'sd0 || out_strobe !== 1'b0 || ovf_flags !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_state: i_out=%0d q_out=%0d strobe=%b flags=%b, want all 0", i_out, q_out, out_strobe, ovf_flags);
    end
    reset_n = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
  endtask

  task automatic test_basic();
    for (int n = 1; n <= 4; n++) cyc(1, 1, n == 4, n, -n, 0, 0);
    n_tests++;
    if (out_strobe !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_early_strobe: strobe=%b, want 0 one edge after dump", out_strobe);
    end
    cyc(1, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (out_strobe !== 1'b1 || i_out !== 16'sd10 || q_out !== -16'sd10) begin
      n_fail++;
      $display("FAIL basic_dump: strobe=%b i=%0d q=%0d, want 1 10 -10", out_strobe, i_out, q_out);
    end
    cyc(1, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (out_strobe !== 1'b0 || i_out !== 16'sd10) begin
      n_fail++;
      $display("FAIL basic_pulse_width: strobe=%b i=%0d, want 0 10", out_strobe, i_out);
    end
    cyc(1, 1, 0, 7, 0, 0, 0);
    cyc(1, 1, 1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (out_strobe !== 1'b1 || i_out !== 16'sd8) begin
      n_fail++;
      $display("FAIL basic_clean_window: strobe=%b i=%0d, want 1 8", out_strobe, i_out);
    end
  endtask

  task automatic test_round();
    cyc(1, 1, 0, 2, -2, 2, 0);
    cyc(1, 1, 1, 4, -4, 2, 0);
    cyc(1, 0, 0, 0, 0, 2, 0);
    n_tests++;
    if (out_strobe !== 1'b1 || i_out !== 16'sd2 || q_out !== -16'sd1) begin
      n_fail++;
      $display("FAIL round_shift2: strobe=%b i=%0d q=%0d, want 1 2 -1", out_strobe, i_out, q_out);
    end
  endtask

  task automatic test_out_sat();
    for (int n = 1; n <= 16; n++) cyc(1, 1, n == 16, 32767, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (out_strobe !== 1'b1 || i_out !== 16'sd32767 || ovf_flags !== 2'b10) begin
      n_fail++;
      $display("FAIL out_sat: strobe=%b i=%0d flags=%b, want 1 32767 10", out_strobe, i_out, ovf_flags);
    end
    cyc(1, 0, 0, 0, 0, 0, 1);
    n_tests++;
    if (ovf_flags !== 2'b00) begin
      n_fail++;
      $display("FAIL out_sat_clear: flags=%b, want 00", ovf_flags);
    end
  endtask

  task automatic test_acc_sat();
    for (int n = 1; n <= 300; n++) begin
      cyc(1, 1, n == 300, 32767, 0, 9, n == 257 || n == 280);
      if (n == 256 || n == 257 || n == 280) begin
        n_tests++;
        if (ovf_flags[0] !== (n != 256)) begin
          n_fail++;
          $display("FAIL acc_sat_flag_%0d: flag0=%b, want %b", n, ovf_flags[0], n != 256);
        end
      end
    end
    cyc(1, 0, 0, 0, 0, 9, 0);
    n_tests++;
    if (out_strobe !== 1'b1 || i_out !== 16'sd16384 || q_out !== 16'sd0 || ovf_flags !== 2'b01) begin
      n_fail++;
      $display("FAIL acc_sat_dump: strobe=%b i=%0d q=%0d flags=%b, want 1 16384 0 01", out_strobe, i_out, q_out, ovf_flags);
    end
    cyc(1, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 10; k++) begin
      cyc(1, 1, 1, 5, 3, 0, 0);
      if (k > 0) begin
        n_tests++;
        if (out_strobe !== 1'b1 || i_out !== 16'sd5 || q_out !== 16'sd3) begin
          n_fail++;
          $display("FAIL back_to_back_%0d: strobe=%b i=%0d q=%0d, want 1 5 3", k, out_strobe, i_out, q_out);
        end
      end
    end
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (out_strobe !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back_end: strobe=%b, want 0", out_strobe);
    end
  endtask

  task automatic test_flush();
    cyc(1, 1, 0, 9, 9, 0, 0);
    cyc(1, 1, 0, 9, 9, 0, 0);
    reset_n = 1'b0;
    #2;
    n_tests++;
    if (i_out !== 16'sd0 || q_out !== 16'sd0 || out_strobe !== 1'b0 || ovf_flags !== 2'b00) begin
      n_fail++;
      $display("FAIL async_reset: i=%0d q=%0d strobe=%b flags=%b, want all 0", i_out, q_out, out_strobe, ovf_flags);
    end
    #2;
    reset_n = 1'b1;
    model_reset();
    cyc(1, 1, 1, 3, -3, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (out_strobe !== 1'b1 || i_out !== 16'sd3 || q_out !== -16'sd3) begin
      n_fail++;
      $display("FAIL reset_discards_window: strobe=%b i=%0d q=%0d, want 1 3 -3", out_strobe, i_out, q_out);
    end
    cyc(1, 1, 1, 4, 4, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (out_strobe !== 1'b0 || i_out !== 16'sd3) begin
      n_fail++;
      $display("FAIL enable_flush: strobe=%b i=%0d, want 0 3", out_strobe, i_out);
    end
    cyc(1, 1, 0, 2, 2, 0, 0);
    cyc(0, 1, 0, 2, 2, 0, 0);
    cyc(1, 1, 1, 1, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (out_strobe !== 1'b1 || i_out !== 16'sd1) begin
      n_fail++;
      $display("FAIL enable_drops_partial: strobe=%b i=%0d, want 1 1", out_strobe, i_out);
    end
  endtask

  task automatic test_random();
    int sh = 0;
    bit ds;
    for (int k = 0; k < 600; k++) begin
      ds = $urandom_range(0, 5) == 0;
      cyc($urandom_range(0, 29) != 0, $urandom_range(0, 3) != 0, ds,
          int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
          sh, $urandom_range(0, 19) == 0);
      if (ds) sh = $urandom_range(0, 15);
      n_tests++;
      if (out_strobe !== mstb || i_out !== 16'(mout[0]) || q_out !== 16'(mout[1]) || ovf_flags !== mflags) begin
        n_fail++;
        $display("FAIL random_%0d: strobe=%b i=%0d q=%0d flags=%b, want %b %0d %0d %b",
                 k, out_strobe, i_out, q_out, ovf_flags, mstb, mout[0], mout[1], mflags);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round();
    test_out_sat();
    test_acc_sat();
    test_back_to_back();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
